bidirect_bus_responder: RTL and testbench

- Synthesizable target/responder for the bidirect bus (addr, write_data, rnw, valid / ready, read_data, error).
- Answers transactions from the bus driver, backed by a word-addressed local memory, with a configurable wait-state count and a stall input.
- Flags out-of-range and misaligned accesses with an error response and counts completed transactions.
- Used as the memory-model endpoint in block benches and as a simple on-chip scratch target.

---
 rtl/bidirect_bus_responder.sv | 148 ++++++++++++++
 tb/tb_bidirect_bus_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bidirect_bus_responder.sv
// rtl/bidirect_bus_responder.sv - bidirect bus target backed by a word-addressed local memory
//
// Accepts one request at a time from the bus initiator, waits WAIT_STATES
// unstalled cycles, then answers with a one-cycle ready pulse carrying
// read_data/error. Misaligned or out-of-range addresses get an error response.
// Completed writes, reads and errors are counted in saturating counters.
//
// Ports:
//   clk        in   bus clock, all logic on posedge
//   reset      in   synchronous active-high reset (clears memory and counters)
//   addr       in   32-bit byte address
//   write_data in   32-bit write data (used when rnw=0)
//   rnw        in   1 = read, 0 = write
//   valid      in   request, held by the initiator until ready is seen
//   stall      in   freezes the wait-state countdown
//   ready      out  one-cycle completion pulse
//   read_data  out  read result, held after the pulse
//   error      out  error flag, valid with ready
//   wr_count   out  successful writes (saturating)
//   rd_count   out  successful reads (saturating)
//   err_count  out  errored transactions (saturating)
module bidirect_bus_responder #(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      addr,
    input  logic [31:0]      write_data,
    input  logic             rnw,
    input  logic             valid,
    input  logic             stall,
    output logic             ready,
    output logic [31:0]      read_data,
    output logic             error,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        fire;
    logic [3:0]  wait_cnt;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_rnw;
    logic        addr_err;
    logic [AW-1:0] word_idx;

    logic [31:0] mem [MEM_DEPTH];

    // Every request passes through WAIT at least once so that the response
    // edge is always one cycle after the last wait state, including when
    // WAIT_STATES is zero.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fire      = 1'b0;
        case (state)
            S_IDLE: begin
                if (valid) begin
                    accept    = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!stall && wait_cnt == 4'd0) begin
                    fire      = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Decode is done on the captured address so late bus changes cannot leak in.
    assign addr_err = (cap_addr[1:0] != 2'b00) || (cap_addr[31:AW+2] != '0);
    assign word_idx = cap_addr[AW+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ready     <= 1'b0;
            error     <= 1'b0;
            read_data <= '0;
            wr_count  <= '0;
            rd_count  <= '0;
            err_count <= '0;
            wait_cnt  <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_rnw   <= 1'b1;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            ready <= fire;
            error <= fire && addr_err;

            if (accept) begin
                cap_addr  <= addr;
                cap_wdata <= write_data;
                cap_rnw   <= rnw;
                wait_cnt  <= 4'(WAIT_STATES);
            end else if (state == S_WAIT && !stall && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (fire) begin
                if (addr_err) begin
                    read_data <= '0;
                    if (err_count != '1) begin
                        err_count <= err_count + 1'b1;
                    end
                end else if (cap_rnw) begin
                    read_data <= mem[word_idx];
                    if (rd_count != '1) begin
                        rd_count <= rd_count + 1'b1;
                    end
                end else begin
                    mem[word_idx] <= cap_wdata;
                    read_data     <= '0;
                    if (wr_count != '1) begin
                        wr_count <= wr_count + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bidirect_bus_responder.sv
// tb/tb_bidirect_bus_responder.sv - self-checking bench for bidirect_bus_responder
module tb_bidirect_bus_responder;

    localparam int DEPTH = 256;
    localparam int WS    = 2;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   addr = '0;
    logic [31:0]   write_data = '0;
    logic          rnw = 1'b1;
    logic          valid = 1'b0;
    logic          stall = 1'b0;
    logic          ready;
    logic [31:0]   read_data;
    logic          error;
    logic [CW-1:0] wr_count;
    logic [CW-1:0] rd_count;
    logic [CW-1:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [31:0] m_mem [DEPTH];
    int m_wr;
    int m_rd;
    int m_err;

    bidirect_bus_responder #(
        .MEM_DEPTH(DEPTH),
        .WAIT_STATES(WS),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .addr(addr),
        .write_data(write_data),
        .rnw(rnw),
        .valid(valid),
        .stall(stall),
        .ready(ready),
        .read_data(read_data),
        .error(error),
        .wr_count(wr_count),
        .rd_count(rd_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [CW-1:0] sat(input int v);
        return (v >= (1 << CW) - 1) ? {CW{1'b1}} : CW'(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_wr = 0;
        m_rd = 0;
        m_err = 0;
    endtask

    task automatic do_reset();
        valid = 1'b0;
        stall = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One transaction; DUT must be idle on entry and is idle on return.
    task automatic txn(input logic r, input logic [31:0] a, input logic [31:0] d,
                       input int stall_pct, input int stall_run, input bit hold,
                       input logic nr, input logic [31:0] na, input logic [31:0] nd,
                       output int lat, output int rdy_at);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          unst;
        bit          done;
        rnw = r; addr = a; write_data = d; valid = 1'b1; stall = 1'($urandom);
        @(posedge clk); #1;
        exp_err = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
        if (exp_err) begin
            exp_rd = '0; m_err++;
        end else if (r) begin
            exp_rd = m_mem[a[9:2]]; m_rd++;
        end else begin
            m_mem[a[9:2]] = d; exp_rd = '0; m_wr++;
        end
        // valid stays high through the wait; fields change and must be ignored
        addr = $urandom; write_data = $urandom; rnw = 1'($urandom);
        unst = 0; done = 0; lat = 0; rdy_at = 0;
        for (int e = 1; e < 200 && !done; e++) begin
            stall = (e <= stall_run) || (int'($urandom_range(99)) < stall_pct);
            @(posedge clk); #1;
            if (!stall) unst++;
            n_cmp++;
            if (ready !== (unst == WS + 1)) begin
                n_bad++;
                $display("FAIL ready_timing edge %0d: ready=%b expected %b", e, ready, unst == WS + 1);
            end
            if (unst == WS + 1) begin
                done = 1; lat = e; rdy_at = cyc;
            end
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL ready_timeout: no response within bound, expected one");
        end
        n_cmp++;
        if (error !== exp_err) begin
            n_bad++;
            $display("FAIL error_flag addr=%h: got %b expected %b", a, error, exp_err);
        end
        n_cmp++;
        if (read_data !== exp_rd) begin
            n_bad++;
            $display("FAIL read_data addr=%h: got %h expected %h", a, read_data, exp_rd);
        end
        n_cmp++;
        if (wr_count !== sat(m_wr) || rd_count !== sat(m_rd) || err_count !== sat(m_err)) begin
            n_bad++;
            $display("FAIL counters: got wr=%0d rd=%0d err=%0d expected wr=%0d rd=%0d err=%0d",
                     wr_count, rd_count, err_count, sat(m_wr), sat(m_rd), sat(m_err));
        end
        stall = 1'($urandom);
        if (hold) begin
            rnw = nr; addr = na; write_data = nd;
        end else begin
            valid = 1'b0;
        end
        @(posedge clk); #1;
        stall = 1'b0;
        n_cmp++;
        if (ready !== 1'b0 || error !== 1'b0 || read_data !== exp_rd) begin
            n_bad++;
            $display("FAIL after_resp: got ready=%b error=%b rd=%h expected 0 0 %h",
                     ready, error, read_data, exp_rd);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (ready !== 1'b0 || error !== 1'b0 || read_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ready=%b error=%b rd=%h expected 0 0 0", ready, error, read_data);
        end
        n_cmp++;
        if (wr_count !== '0 || rd_count !== '0 || err_count !== '0) begin
            n_bad++;
            $display("FAIL reset_counters: got %0d %0d %0d expected 0 0 0", wr_count, rd_count, err_count);
        end
    endtask

    task automatic test_basic();
        int lat, at;
        txn(1'b0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 1'b0, 0, 0, lat, at);
        n_cmp++;
        if (lat !== 3) begin n_bad++; $display("FAIL write_latency: got %0d expected 3", lat); end
        txn(1'b1, 32'h10, 32'h0, 0, 0, 0, 1'b0, 0, 0, lat, at);
        n_cmp++;
        if (lat !== 3) begin n_bad++; $display("FAIL read_latency: got %0d expected 3", lat); end
        n_cmp++;
        if (read_data !== 32'hDEADBEEF || wr_count !== 4'd1 || rd_count !== 4'd1) begin
            n_bad++;
            $display("FAIL basic_rw: got rd=%h wr=%0d rdc=%0d expected deadbeef 1 1", read_data, wr_count, rd_count);
        end
    endtask

    task automatic test_errors();
        int lat, at;
        txn(1'b1, 32'h400, 32'h0, 0, 0, 0, 1'b0, 0, 0, lat, at);
        txn(1'b0, 32'h13, 32'h12345678, 0, 0, 0, 1'b0, 0, 0, lat, at);
        n_cmp++;
        if (err_count !== 4'd2) begin n_bad++; $display("FAIL err_count: got %0d expected 2", err_count); end
        txn(1'b1, 32'h10, 32'h0, 30, 0, 0, 1'b0, 0, 0, lat, at);
        n_cmp++;
        if (read_data !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL err_no_write: got %h expected deadbeef", read_data);
        end
    endtask

    task automatic test_stall();
        int lat, at;
        txn(1'b0, 32'h20, 32'hA5A5_0001, 0, 4, 0, 1'b0, 0, 0, lat, at);
        n_cmp++;
        if (lat !== 7) begin n_bad++; $display("FAIL stall_latency: got %0d expected 7", lat); end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, at1, at2;
        do_reset();
        txn(1'b0, 32'h0, 32'h1, 0, 0, 1, 1'b0, 32'h4, 32'h2, lat1, at1);
        txn(1'b0, 32'h4, 32'h2, 0, 0, 0, 1'b0, 0, 0, lat2, at2);
        n_cmp++;
        if (at2 - at1 !== 5) begin n_bad++; $display("FAIL b2b_gap: got %0d expected 5", at2 - at1); end
        n_cmp++;
        if (wr_count !== 4'd2) begin n_bad++; $display("FAIL b2b_wr_count: got %0d expected 2", wr_count); end
        txn(1'b1, 32'h4, 32'h0, 0, 0, 0, 1'b0, 0, 0, lat1, at1);
        n_cmp++;
        if (read_data !== 32'h2) begin n_bad++; $display("FAIL b2b_data: got %h expected 2", read_data); end
    endtask

    task automatic test_reset_mid();
        int lat, at;
        rnw = 1'b0; addr = 32'h8; write_data = 32'hCAFE_F00D; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_mid_ready: got %b expected 0", ready); end
        end
        n_cmp++;
        if (wr_count !== '0 || rd_count !== '0 || err_count !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_counters: got %0d %0d %0d expected 0 0 0", wr_count, rd_count, err_count);
        end
        txn(1'b1, 32'h8, 32'h0, 0, 0, 0, 1'b0, 0, 0, lat, at);
        n_cmp++;
        if (read_data !== 32'h0) begin n_bad++; $display("FAIL reset_mid_mem: got %h expected 0", read_data); end
    endtask

    task automatic test_random();
        int lat, at;
        logic [31:0] a;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(9))
                0: a = $urandom;
                1: a = {24'h0, 3'($urandom_range(7)), 3'($urandom), 2'($urandom_range(3, 1))};
                2: a = 32'h400 + {22'h0, 8'($urandom), 2'b00};
                default: a = {25'h0, 5'($urandom_range(31)), 2'b00};
            endcase
            txn(1'($urandom), a, $urandom, 30, 0, 0, 1'b0, 0, 0, lat, at);
        end
    endtask

    task automatic test_saturation();
        int lat, at;
        do_reset();
        for (int n = 0; n < 17; n++) begin
            txn(1'b1, 32'h0, 32'h0, 0, 0, 0, 1'b0, 0, 0, lat, at);
        end
        n_cmp++;
        if (rd_count !== 4'hF) begin n_bad++; $display("FAIL rd_saturate: got %h expected f", rd_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
